// File: rtl/fb_pkg.sv
// Shared types and sizing helpers for the VGA frame buffer.
package fb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } scan_state_t;

  localparam int SKID_DEPTH = 2;
  localparam int SKID_CNT_W = $clog2(SKID_DEPTH + 1);

  function automatic int fb_depth(input int h_words, input int v_lines);
    return h_words * v_lines;
  endfunction

  function automatic int fb_be_w(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/fb_skid_buffer.sv
// Two-entry valid/ready buffer for {sof, sol, data} scan beats, with flush.
module fb_skid_buffer
  import fb_pkg::*;
#(
  parameter int W = 18
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  push,
  input  logic [W-1:0]          push_data,
  input  logic                  pop,
  output logic [SKID_CNT_W-1:0] count,
  output logic                  valid,
  output logic [W-1:0]          head
);

  logic [W-1:0] e0_q, e1_q;
  logic [SKID_CNT_W-1:0] cnt_q;

  // The issue credit guarantees no push into a full buffer and no pop when empty.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      e0_q  <= '0;
      e1_q  <= '0;
    end else if (flush) begin
      cnt_q <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt_q == '0) e0_q <= push_data;
          else             e1_q <= push_data;
          cnt_q <= cnt_q + SKID_CNT_W'(1);
        end
        2'b01: begin
          e0_q  <= e1_q;
          cnt_q <= cnt_q - SKID_CNT_W'(1);
        end
        2'b11: begin
          if (cnt_q == SKID_CNT_W'(1)) begin
            e0_q <= push_data;
          end else begin
            e0_q <= e1_q;
            e1_q <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign count = cnt_q;
  assign valid = (cnt_q != '0);
  assign head  = e0_q;

endmodule

// File: rtl/vga_frame_buffer.sv
// Dual-port VGA frame buffer: Avalon-MM pixel port plus a scan-out streamer.
// Optional FB_LINE_DOUBLE_EN emits every line twice (frame of 2*V_LINES lines).
//   state | meaning
//   IDLE  | no frame active, waiting for sof_req
//   RUN   | issuing port-B reads in address order
//   DRAIN | last read issued, emptying the skid buffer
module vga_frame_buffer
  import fb_pkg::*;
#(
  parameter int    DATA_W       = 16,
  parameter int    H_WORDS      = 160,
  parameter int    V_LINES      = 120,
  parameter int    ADDR_W       = 15,
  parameter int    READ_LATENCY = 1,
  parameter string INIT_FILE    = "tv.hex"
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [ADDR_W-1:0]            address,
  input  logic                         chipselect,
  input  logic                         read,
  input  logic                         write,
  input  logic [fb_be_w(DATA_W)-1:0]   byteenable,
  input  logic [DATA_W-1:0]            writedata,
  input  logic                         clken,
  output logic                         waitrequest,
  output logic [DATA_W-1:0]            readdata,
  output logic                         readdatavalid,
  input  logic                         sof_req,
  input  logic                         pix_ready,
  output logic                         pix_valid,
  output logic [DATA_W-1:0]            pix_data,
  output logic                         pix_sol,
  output logic                         pix_sof,
  output logic                         frame_done
);

  localparam int DEPTH = fb_depth(H_WORDS, V_LINES);
  localparam int BE_W  = fb_be_w(DATA_W);
  localparam int COL_W = $clog2(H_WORDS);

  logic [DATA_W-1:0] mem [DEPTH];

  logic acc, rd_acc, wr_acc, a_in_range;
  logic issue;
  logic [ADDR_W-1:0] scan_addr_q, addr_d;
  logic [DATA_W-1:0] b_data_q;

  assign acc        = chipselect & clken;
  assign a_in_range = 32'(address) < DEPTH;
  assign wr_acc     = acc & write & a_in_range;
  assign rd_acc     = acc & read & ~write;
  assign waitrequest = ~clken;

  // Both ports use non-blocking access, so a same-address read sees the old word.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      for (int b = 0; b < BE_W; b++) begin
        if (byteenable[b]) mem[address][b*8 +: 8] <= writedata[b*8 +: 8];
      end
    end
    if (issue) b_data_q <= mem[scan_addr_q];
  end

  logic [READ_LATENCY-1:0]             rdv_q;
  logic [READ_LATENCY-1:0][DATA_W-1:0] rdd_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdv_q <= '0;
      rdd_q <= '0;
    end else if (clken) begin
      rdv_q[0] <= rd_acc;
      rdd_q[0] <= (rd_acc & a_in_range) ? mem[address] : '0;
      for (int i = 1; i < READ_LATENCY; i++) begin
        rdv_q[i] <= rdv_q[i-1];
        rdd_q[i] <= rdd_q[i-1];
      end
    end
  end

  // Masked while stalled so a held pipeline stage is reported only once.
  assign readdatavalid = rdv_q[READ_LATENCY-1] & clken;
  assign readdata      = rdd_q[READ_LATENCY-1];

  scan_state_t state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic infl_q, infl_d, infl_sol_q, infl_sof_q;
  logic done_q, done_d;
  logic tag_sol, tag_sof, pop;
  logic [SKID_CNT_W-1:0] sk_count;
  logic sk_valid;
  logic [DATA_W+1:0] sk_head;
`ifdef FB_LINE_DOUBLE_EN
  logic replay_q, replay_d;
  logic [ADDR_W-1:0] base_q, base_d;
  assign tag_sof = (scan_addr_q == '0) & ~replay_q;
`else
  assign tag_sof = (scan_addr_q == '0);
`endif
  assign tag_sol = (col_q == '0);
  assign pop     = sk_valid & pix_ready;

  always_comb begin
    state_d = state_q;
    addr_d  = scan_addr_q;
    col_d   = col_q;
    infl_d  = 1'b0;
    done_d  = 1'b0;
    issue   = 1'b0;
`ifdef FB_LINE_DOUBLE_EN
    replay_d = replay_q;
    base_d   = base_q;
`endif
    case (state_q)
      RUN: begin
        // Credit counts the beat leaving this cycle so the stream sustains 1 word/cycle.
        if (({1'b0, sk_count} + (SKID_CNT_W+1)'(infl_q)) <
            ((SKID_CNT_W+1)'(SKID_DEPTH) + (SKID_CNT_W+1)'(pop))) begin
          issue  = 1'b1;
          infl_d = 1'b1;
          col_d  = (col_q == COL_W'(H_WORDS-1)) ? '0 : col_q + COL_W'(1);
`ifdef FB_LINE_DOUBLE_EN
          if (col_q == COL_W'(H_WORDS-1)) begin
            if (!replay_q) begin
              replay_d = 1'b1;
              addr_d   = base_q;
            end else begin
              replay_d = 1'b0;
              addr_d   = scan_addr_q + ADDR_W'(1);
              base_d   = scan_addr_q + ADDR_W'(1);
            end
          end else begin
            addr_d = scan_addr_q + ADDR_W'(1);
          end
          if (replay_q && scan_addr_q == ADDR_W'(DEPTH-1)) state_d = DRAIN;
`else
          addr_d = scan_addr_q + ADDR_W'(1);
          if (scan_addr_q == ADDR_W'(DEPTH-1)) state_d = DRAIN;
`endif
        end
      end
      DRAIN: begin
        if (pop && sk_count == SKID_CNT_W'(1) && !infl_q) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      IDLE: ;
      default: state_d = IDLE;
    endcase
    // Restart overrides everything except a frame_done already earned this cycle.
    if (sof_req) begin
      state_d = RUN;
      addr_d  = '0;
      col_d   = '0;
      infl_d  = 1'b0;
      issue   = 1'b0;
`ifdef FB_LINE_DOUBLE_EN
      replay_d = 1'b0;
      base_d   = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      scan_addr_q <= '0;
      col_q       <= '0;
      infl_q      <= 1'b0;
      infl_sol_q  <= 1'b0;
      infl_sof_q  <= 1'b0;
      done_q      <= 1'b0;
`ifdef FB_LINE_DOUBLE_EN
      replay_q    <= 1'b0;
      base_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      scan_addr_q <= addr_d;
      col_q       <= col_d;
      infl_q      <= infl_d;
      done_q      <= done_d;
      if (issue) begin
        infl_sol_q <= tag_sol;
        infl_sof_q <= tag_sof;
      end
`ifdef FB_LINE_DOUBLE_EN
      replay_q    <= replay_d;
      base_q      <= base_d;
`endif
    end
  end

  fb_skid_buffer #(.W(DATA_W + 2)) u_skid (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (sof_req),
    .push      (infl_q),
    .push_data ({infl_sof_q, infl_sol_q, b_data_q}),
    .pop       (pop),
    .count     (sk_count),
    .valid     (sk_valid),
    .head      (sk_head)
  );

  assign pix_valid  = sk_valid;
  assign pix_data   = sk_head[DATA_W-1:0];
  assign pix_sol    = sk_valid & sk_head[DATA_W];
  assign pix_sof    = sk_valid & sk_head[DATA_W+1];
  assign frame_done = done_q;

endmodule

// File: tb/tb_vga_frame_buffer.sv
// Self-checking bench for vga_frame_buffer: Avalon port at latency 1 and 2, scan-out stream.
module tb_vga_frame_buffer;

  localparam int H     = 160;
  localparam int V     = 120;
  localparam int DEPTH = H * V;
`ifdef FB_LINE_DOUBLE_EN
  localparam int TOTAL = 2 * DEPTH;
`else
  localparam int TOTAL = DEPTH;
`endif

  logic        clk, reset_n;
  logic [14:0] address;
  logic        chipselect, read, write, clken;
  logic [1:0]  byteenable;
  logic [15:0] writedata;
  logic        sof_req, pix_ready;
  logic        waitrequest, readdatavalid, pix_valid, pix_sol, pix_sof, frame_done;
  logic [15:0] readdata, pix_data;
  logic        sof_req2, pix_ready2;
  logic        waitrequest2, readdatavalid2, pix_valid2, pix_sol2, pix_sof2, frame_done2;
  logic [15:0] readdata2, pix_data2;

  vga_frame_buffer #(.READ_LATENCY(1), .INIT_FILE("")) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .read(read), .write(write), .byteenable(byteenable), .writedata(writedata),
    .clken(clken), .waitrequest(waitrequest), .readdata(readdata),
    .readdatavalid(readdatavalid), .sof_req(sof_req), .pix_ready(pix_ready),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_sol(pix_sol), .pix_sof(pix_sof),
    .frame_done(frame_done)
  );

  vga_frame_buffer #(.READ_LATENCY(2), .INIT_FILE("")) dut2 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .read(read), .write(write), .byteenable(byteenable), .writedata(writedata),
    .clken(clken), .waitrequest(waitrequest2), .readdata(readdata2),
    .readdatavalid(readdatavalid2), .sof_req(sof_req2), .pix_ready(pix_ready2),
    .pix_valid(pix_valid2), .pix_data(pix_data2), .pix_sol(pix_sol2), .pix_sof(pix_sof2),
    .frame_done(frame_done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] model_mem [DEPTH];

  int beat;
  bit stalled_prev;
  logic [15:0] hold_data;
  logic hold_sol, hold_sof;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int exp_addr(input int k);
`ifdef FB_LINE_DOUBLE_EN
    return (k / (2 * H)) * H + (k % H);
`else
    return k;
`endif
  endfunction

  function automatic logic [15:0] model_rd(input int a);
    return (a < DEPTH) ? model_mem[a] : 16'h0;
  endfunction

  task automatic bus_idle();
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0; write = 1'b0;
  endtask

  task automatic avm_write(input int a, input logic [15:0] d, input logic [1:0] be);
    @(negedge clk);
    chipselect = 1'b1; write = 1'b1; read = 1'b0;
    address = 15'(a); writedata = d; byteenable = be;
    if (a < DEPTH) begin
      if (be[0]) model_mem[a][7:0]  = d[7:0];
      if (be[1]) model_mem[a][15:8] = d[15:8];
    end
  endtask

  task automatic avm_read_check(input int a, input logic [15:0] exp);
    @(negedge clk);
    chipselect = 1'b1; read = 1'b1; write = 1'b0; address = 15'(a);
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0;
    #1;
    chk("rd_l1_valid", 32'(readdatavalid), 32'(1'b1));
    chk("rd_l1_data", 32'(readdata), 32'(exp));
    chk("rd_l2_early", 32'(readdatavalid2), 32'(1'b0));
    @(negedge clk);
    #1;
    chk("rd_l2_valid", 32'(readdatavalid2), 32'(1'b1));
    chk("rd_l2_data", 32'(readdata2), 32'(exp));
    chk("rd_l1_once", 32'(readdatavalid), 32'(1'b0));
  endtask

  // One scan-port observation in the current cycle (inputs already driven).
  task automatic sample_cycle();
    if (stalled_prev) begin
      chk("stall_valid", 32'(pix_valid), 32'(1'b1));
      chk("stall_data", 32'(pix_data), 32'(hold_data));
      chk("stall_tags", 32'({pix_sof, pix_sol}), 32'({hold_sof, hold_sol}));
    end
    chk("done_early", 32'(frame_done), 32'(1'b0));
    if (pix_valid && pix_ready) begin
      chk("pix_data", 32'(pix_data), 32'(model_mem[exp_addr(beat)]));
      chk("pix_sol", 32'(pix_sol), 32'((beat % H) == 0));
      chk("pix_sof", 32'(pix_sof), 32'(beat == 0));
      beat++;
    end
    stalled_prev = pix_valid && !pix_ready;
    hold_data = pix_data;
    hold_sol  = pix_sol;
    hold_sof  = pix_sof;
  endtask

  task automatic do_sof(input bit rdy);
    @(negedge clk);
    sof_req = 1'b1;
    pix_ready = rdy;
    #1;
    sample_cycle();
    beat = 0;
    stalled_prev = 1'b0;
    @(negedge clk);
    sof_req = 1'b0;
    pix_ready = 1'b0;
    #1;
    chk("sof_gap", 32'(pix_valid), 32'(1'b0));
  endtask

  task automatic scan(input int stop_at, input int pct);
    int cyc = 0;
    int limit = (stop_at - beat) * 50 + 100;
    while (beat < stop_at && cyc < limit) begin
      @(negedge clk);
      pix_ready = ($urandom_range(99) < pct);
      #1;
      if (pct == 100 && beat > 0) chk("no_bubble", 32'(pix_valid), 32'(1'b1));
      sample_cycle();
      cyc++;
    end
    if (beat < stop_at) chk("scan_timeout", 32'(beat), 32'(stop_at));
  endtask

  initial begin
    int got1, got2, idx, a;
    logic [15:0] d;
    reset_n = 1'b0; address = '0; chipselect = 1'b0; read = 1'b0; write = 1'b0;
    byteenable = '0; writedata = '0; clken = 1'b1; sof_req = 1'b0; pix_ready = 1'b0;
    sof_req2 = 1'b0; pix_ready2 = 1'b0;
    beat = 0; stalled_prev = 1'b0; hold_data = '0; hold_sol = 1'b0; hold_sof = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_readdata", 32'(readdata), 32'h0);
    chk("rst_rdvalid", 32'({readdatavalid, readdatavalid2}), 32'h0);
    chk("rst_waitreq", 32'(waitrequest), 32'h0);
    chk("rst_pix", 32'({pix_valid, pix_sol, pix_sof, frame_done}), 32'h0);
    chk("rst_pix_data", 32'(pix_data), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < DEPTH; i++) avm_write(i, 16'($urandom), 2'b11);
    bus_idle();

    avm_write(5, 16'hBEEF, 2'b11);
    avm_write(5, 16'h0012, 2'b01);
    avm_read_check(5, 16'hBE12);

    for (int n = 0; n < 6; n++) begin
      a = $urandom_range(DEPTH - 1);
      d = 16'($urandom);
      avm_write(a, d, 2'($urandom_range(3)));
      avm_read_check(a, model_rd(a));
    end

    avm_write(DEPTH + 7, 16'h5555, 2'b11);
    avm_read_check(DEPTH + 7, 16'h0000);
    avm_read_check(32767, 16'h0000);
    avm_read_check(7, model_rd(7));

    @(negedge clk);
    chipselect = 1'b1; read = 1'b1; write = 1'b1; address = 15'd9;
    writedata = 16'hA5A5; byteenable = 2'b11;
    model_mem[9] = 16'hA5A5;
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0; write = 1'b0;
    #1;
    chk("rw_no_read_l1", 32'(readdatavalid), 32'h0);
    @(negedge clk);
    #1;
    chk("rw_no_read_l2", 32'(readdatavalid2), 32'h0);
    avm_read_check(9, 16'hA5A5);

    got1 = 0; got2 = 0; idx = 0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      @(negedge clk);
      clken = !(cyc >= 4 && cyc < 7);
      chipselect = (idx < 8); read = (idx < 8); write = 1'b0; address = 15'(idx);
      if (clken && idx < 8) idx++;
      #1;
      chk("waitreq", 32'({waitrequest, waitrequest2}), clken ? 32'h0 : 32'h3);
      if (readdatavalid) begin
        chk("burst_l1_data", 32'(readdata), 32'(model_mem[got1 % 8]));
        got1++;
      end
      if (readdatavalid2) begin
        chk("burst_l2_data", 32'(readdata2), 32'(model_mem[got2 % 8]));
        got2++;
      end
    end
    chk("burst_l1_count", 32'(got1), 32'd8);
    chk("burst_l2_count", 32'(got2), 32'd8);
    clken = 1'b1;
    bus_idle();

    do_sof(1'b0);
    scan(1000, 50);
    do_sof(1'b0);
    scan(300, 50);
    do_sof(1'b1);
    scan(TOTAL, 100);
    @(negedge clk);
    pix_ready = 1'b1;
    #1;
    chk("frame_done", 32'(frame_done), 32'h1);
    chk("frame_end_valid", 32'(pix_valid), 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      chk("idle_done", 32'(frame_done), 32'h0);
      chk("idle_valid", 32'(pix_valid), 32'h0);
    end

    do_sof(1'b0);
    scan(50, 100);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_pix", 32'({pix_valid, pix_sol, pix_sof, frame_done}), 32'h0);
    chk("arst_pix_data", 32'(pix_data), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    pix_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk("arst_idle", 32'(pix_valid), 32'h0);
    end
    beat = 0;
    stalled_prev = 1'b0;
    do_sof(1'b0);
    scan(20, 100);

    chk("l2_scan_quiet", 32'({pix_valid2, pix_sol2, pix_sof2, frame_done2}), 32'h0);
    chk("l2_pix_data", 32'(pix_data2), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
